// File: rtl/pwm_duty_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_duty_sequencer
//
// Owns the duty-cycle setting of the PWM generator. A new target duty comes
// either from a valid/ready handshake or from debounced inc/dec buttons. The
// applied duty then ramps one count at a time toward the target. Every change
// is committed only on a PWM period boundary, so the compare value never moves
// in the middle of a period.
//
// Optional feature (macro PWM_SEQ_RETARGET_EN):
//   When defined, a new target may also be accepted while ramping. It
//   replaces the in-flight target and the ramp direction is recomputed.
//   When undefined, targets are accepted in IDLE only.
//
// Handshake: a target transfers on any clock edge where tgt_valid and
// tgt_ready are both high. tgt_ready is decoded from the state only and never
// looks at tgt_valid. The source holds tgt_duty stable while tgt_valid is high.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   inc_btn      in   raw increase button (asynchronous)
//   dec_btn      in   raw decrease button (asynchronous)
//   period_wrap  in   one-cycle pulse when the PWM counter returns to 0
//   tgt_valid    in   target duty offered
//   tgt_duty     in   requested duty (values above DUTY_MAX are clamped)
//   tgt_ready    out  target accepted when tgt_valid & tgt_ready
//   duty_out     out  applied duty, drives the PWM compare
//   duty_update  out  one-cycle pulse in the cycle duty_out takes a new value
//   busy         out  high while ramping; also exposes the FSM state
// -----------------------------------------------------------------------------
module pwm_duty_sequencer #(
    parameter int DUTY_W    = 4,
    parameter int DUTY_MAX  = 10,
    parameter int DUTY_INIT = 5,
    parameter int STEP_DIV  = 4,
    parameter int DEB_DIV   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_btn,
    input  logic              dec_btn,
    input  logic              period_wrap,
    input  logic              tgt_valid,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic              tgt_ready,
    output logic [DUTY_W-1:0] duty_out,
    output logic              duty_update,
    output logic              busy
);

    localparam logic [DUTY_W-1:0] L_MAX  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] L_INIT = DUTY_W'(DUTY_INIT);

    localparam int STEP_CW = $clog2(STEP_DIV);
    localparam logic [STEP_CW-1:0] L_STEP_LAST = STEP_CW'(STEP_DIV - 1);

    localparam int DEB_CW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [DEB_CW-1:0] L_DEB_LAST = DEB_CW'(DEB_DIV - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Button path. Bit 0 is inc, bit 1 is dec.
    // ------------------------------------------------------------------
    logic [1:0]        w_btn_raw;
    logic [1:0]        r_btn_s1;
    logic [1:0]        r_btn_s2;
    logic [1:0]        r_btn_smp;
    logic [1:0]        r_btn_lvl;
    logic [1:0]        r_btn_req;
    logic [DEB_CW-1:0] r_deb_cnt;
    logic              w_deb_tick;

    assign w_btn_raw  = {dec_btn, inc_btn};
    assign w_deb_tick = (r_deb_cnt == L_DEB_LAST);

    // The debounced level only changes after two consecutive tick samples
    // agree. A glitch shorter than one tick interval therefore never
    // produces a press. The press pulse fires on the 0->1 change of that
    // level and lasts exactly one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1  <= '0;
            r_btn_s2  <= '0;
            r_btn_smp <= '0;
            r_btn_lvl <= '0;
            r_btn_req <= '0;
            r_deb_cnt <= '0;
        end else begin
            r_btn_s1  <= w_btn_raw;
            r_btn_s2  <= r_btn_s1;
            r_deb_cnt <= w_deb_tick ? '0 : r_deb_cnt + DEB_CW'(1);
            if (w_deb_tick) begin
                r_btn_smp <= r_btn_s2;
                r_btn_lvl <= (r_btn_s2 & r_btn_smp) | (r_btn_lvl & (r_btn_s2 | r_btn_smp));
                r_btn_req <= r_btn_s2 & r_btn_smp & ~r_btn_lvl;
            end else begin
                r_btn_req <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [DUTY_W-1:0]  r_duty;
    logic [DUTY_W-1:0]  r_target;
    logic               r_dir_up;
    logic [STEP_CW-1:0] r_step_cnt;
    logic               r_step_due;
    logic               r_update;
    logic               r_busy;

    logic [DUTY_W-1:0]  w_tgt_clamp;
    logic               w_hs;
    logic               w_btn_inc;
    logic               w_btn_dec;
    logic [DUTY_W-1:0]  w_inc_tgt;
    logic [DUTY_W-1:0]  w_dec_tgt;
    logic [DUTY_W-1:0]  w_idle_tgt;
    logic               w_idle_go;
    logic [DUTY_W-1:0]  w_ramp_tgt;
    logic               w_ramp_up;
    logic               w_step_last;
    logic               w_step_fire;
    logic [DUTY_W-1:0]  w_duty_next;

`ifdef PWM_SEQ_RETARGET_EN
    assign tgt_ready = (r_state == S_IDLE) || (r_state == S_RAMP);
`else
    assign tgt_ready = (r_state == S_IDLE);
`endif

    assign w_tgt_clamp = (tgt_duty > L_MAX) ? L_MAX : tgt_duty;
    assign w_hs        = tgt_valid & tgt_ready;

    // Simultaneous inc and dec cancel each other.
    assign w_btn_inc = r_btn_req[0] & ~r_btn_req[1];
    assign w_btn_dec = r_btn_req[1] & ~r_btn_req[0];

    assign w_inc_tgt = (r_duty >= L_MAX) ? L_MAX : r_duty + DUTY_W'(1);
    assign w_dec_tgt = (r_duty == '0) ? '0 : r_duty - DUTY_W'(1);

    // The handshake has priority over a button press in the same cycle.
    // With no request at all the candidate equals r_duty, so nothing starts.
    always_comb begin
        w_idle_tgt = r_duty;
        if (w_hs) begin
            w_idle_tgt = w_tgt_clamp;
        end else if (w_btn_inc) begin
            w_idle_tgt = w_inc_tgt;
        end else if (w_btn_dec) begin
            w_idle_tgt = w_dec_tgt;
        end
    end

    assign w_idle_go = (w_idle_tgt != r_duty);

`ifdef PWM_SEQ_RETARGET_EN
    assign w_ramp_tgt = w_hs ? w_tgt_clamp : r_target;
    assign w_ramp_up  = w_hs ? (w_tgt_clamp > r_duty) : r_dir_up;
`else
    assign w_ramp_tgt = r_target;
    assign w_ramp_up  = r_dir_up;
`endif

    // A step becomes owed every STEP_DIV cycles. It is paid on the next
    // period_wrap, which may be the same edge the debt arises on.
    assign w_step_last = (r_step_cnt == L_STEP_LAST);
    assign w_step_fire = (w_step_last | r_step_due) & period_wrap;
    assign w_duty_next = w_ramp_up ? r_duty + DUTY_W'(1) : r_duty - DUTY_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_duty     <= L_INIT;
            r_target   <= L_INIT;
            r_dir_up   <= 1'b0;
            r_step_cnt <= '0;
            r_step_due <= 1'b0;
            r_update   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_update <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_idle_go) begin
                        r_target   <= w_idle_tgt;
                        r_dir_up   <= (w_idle_tgt > r_duty);
                        r_step_cnt <= '0;
                        r_step_due <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RAMP;
                    end
                end
                S_RAMP: begin
                    r_step_cnt <= w_step_last ? '0 : r_step_cnt + STEP_CW'(1);
                    r_target   <= w_ramp_tgt;
                    r_dir_up   <= w_ramp_up;
                    if (w_ramp_tgt == r_duty) begin
                        // Only reachable by retargeting onto the current duty.
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_step_fire) begin
                        r_step_due <= 1'b0;
                        r_duty     <= w_duty_next;
                        r_update   <= 1'b1;
                        if (w_duty_next == w_ramp_tgt) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_step_last) begin
                        r_step_due <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign duty_out    = r_duty;
    assign duty_update = r_update;
    assign busy        = r_busy;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_sequencer
//
// Directed and random stimulus for pwm_duty_sequencer. The reference model
// describes the ramp in terms of edge numbers: a step is owed at every
// STEP_DIV-th edge after acceptance, and it is paid on the first edge with
// period_wrap high that comes at or after an owed point not yet paid.
// Button scenarios are checked on their end result and on the number of
// update pulses they produce.
// -----------------------------------------------------------------------------
module tb_pwm_duty_sequencer;

    localparam int DUTY_W    = 4;
    localparam int DUTY_MAX  = 10;
    localparam int DUTY_INIT = 5;
    localparam int STEP_DIV  = 4;
    localparam int DEB_DIV   = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              inc_btn;
    logic              dec_btn;
    logic              period_wrap;
    logic              tgt_valid;
    logic [DUTY_W-1:0] tgt_duty;
    logic              tgt_ready;
    logic [DUTY_W-1:0] duty_out;
    logic              duty_update;
    logic              busy;

    pwm_duty_sequencer #(
        .DUTY_W    (DUTY_W),
        .DUTY_MAX  (DUTY_MAX),
        .DUTY_INIT (DUTY_INIT),
        .STEP_DIV  (STEP_DIV),
        .DEB_DIV   (DEB_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_btn     (inc_btn),
        .dec_btn     (dec_btn),
        .period_wrap (period_wrap),
        .tgt_valid   (tgt_valid),
        .tgt_duty    (tgt_duty),
        .tgt_ready   (tgt_ready),
        .duty_out    (duty_out),
        .duty_update (duty_update),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int n_edge   = 0;

    // reference model state
    int m_duty;
    int m_target;
    bit m_busy;
    int m_e0;
    int m_last;

    logic [31:0] upd_q[$];
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready();
`ifdef PWM_SEQ_RETARGET_EN
        return 1'b1;
`else
        return !m_busy;
`endif
    endfunction

    // First owed step point strictly after edge 'last'.
    function automatic int next_bound(input int last);
        return m_e0 + ((last - m_e0) / STEP_DIV + 1) * STEP_DIV;
    endfunction

    task automatic model_reset();
        m_duty   = DUTY_INIT;
        m_target = DUTY_INIT;
        m_busy   = 1'b0;
        m_e0     = 0;
        m_last   = 0;
    endtask

    task automatic model_edge(input bit v, input int d, input bit w, output bit exp_upd);
        int c;
        exp_upd = 1'b0;
        c = (d > DUTY_MAX) ? DUTY_MAX : d;
        if (!m_busy) begin
            if (v && c != m_duty) begin
                m_busy   = 1'b1;
                m_target = c;
                m_e0     = n_edge;
                m_last   = n_edge;
            end
        end else begin
`ifdef PWM_SEQ_RETARGET_EN
            if (v) m_target = c;
`endif
            if (m_target == m_duty) begin
                m_busy = 1'b0;
            end else if (w && next_bound(m_last) <= n_edge) begin
                m_duty  = m_duty + ((m_target > m_duty) ? 1 : -1);
                m_last  = n_edge;
                exp_upd = 1'b1;
                if (m_duty == m_target) m_busy = 1'b0;
            end
        end
    endtask

    // driver: apply inputs for one clock, then check against the model
    task automatic cyc(input bit v, input int d, input bit w);
        bit eu;
        tgt_valid   = v;
        tgt_duty    = DUTY_W'(d);
        period_wrap = w;
        @(posedge clk);
        #1;
        n_edge++;
        model_edge(v, d, w, eu);
        check("duty_out", duty_out, m_duty);
        check("duty_update", duty_update, eu);
        check("busy", busy, m_busy);
        check("tgt_ready", tgt_ready, exp_ready());
        if (duty_update) upd_q.push_back(n_edge);
        tgt_valid = 1'b0;
    endtask

    // free-running cycles for the button scenarios, counting update pulses
    task automatic btn_run(input int n, inout int cnt);
        tgt_valid   = 1'b0;
        period_wrap = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            n_edge++;
            if (duty_update) cnt++;
        end
    endtask

    task automatic compare_queues(input string tag);
        check({tag, "_count"}, upd_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < upd_q.size(); i++)
            check({tag, "_edge"}, upd_q[i], exp_q[i]);
    endtask

    initial begin
        int e0;
        int cnt;
        bit hit;

        inc_btn     = 1'b0;
        dec_btn     = 1'b0;
        period_wrap = 1'b0;
        tgt_valid   = 1'b0;
        tgt_duty    = '0;
        rst_n       = 1'b1;
        model_reset();

        // reset values
        #3 rst_n = 1'b0;
        #1;
        check("rst_duty_out", duty_out, DUTY_INIT);
        check("rst_busy", busy, 0);
        check("rst_update", duty_update, 0);
        check("rst_ready", tgt_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // idle for 20 cycles
        repeat (20) cyc(1'b0, 0, 1'b0);

        // 5 -> 8 with period_wrap held high: updates at E0+4, +8, +12
        upd_q.delete();
        cyc(1'b1, 8, 1'b1);
        e0 = n_edge;
        repeat (14) cyc(1'b0, 0, 1'b1);
        exp_q = {e0 + 4, e0 + 8, e0 + 12};
        compare_queues("ramp_5_8");
        check("ramp_5_8_final", duty_out, 8);

        // 8 -> 9, then an out-of-range request clamps to 10
        cyc(1'b1, 9, 1'b1);
        repeat (6) cyc(1'b0, 0, 1'b1);
        upd_q.delete();
        cyc(1'b1, 15, 1'b1);
        repeat (8) cyc(1'b0, 0, 1'b1);
        check("clamp_final", duty_out, DUTY_MAX);
        check("clamp_steps", upd_q.size(), 1);

        // buttons: inc at the upper limit is a no-op
        cnt = 0;
        inc_btn = 1'b1;
        btn_run(10, cnt);
        inc_btn = 1'b0;
        btn_run(30, cnt);
        check("btn_inc_at_max_updates", cnt, 0);
        check("btn_inc_at_max_duty", duty_out, 10);
        // dec held 10 cycles -> one step down
        cnt = 0;
        dec_btn = 1'b1;
        btn_run(10, cnt);
        dec_btn = 1'b0;
        btn_run(30, cnt);
        check("btn_dec_updates", cnt, 1);
        check("btn_dec_duty", duty_out, 9);
        check("btn_dec_idle", busy, 0);
        // one-cycle glitch is ignored
        cnt = 0;
        dec_btn = 1'b1;
        btn_run(1, cnt);
        dec_btn = 1'b0;
        btn_run(30, cnt);
        check("btn_glitch_updates", cnt, 0);
        check("btn_glitch_duty", duty_out, 9);
        m_duty   = 9;
        m_target = 9;
        m_busy   = 1'b0;

        // back to 5, then ramp to 3 with period_wrap every 10 cycles
        cyc(1'b1, 5, 1'b1);
        repeat (20) cyc(1'b0, 0, 1'b1);
        upd_q.delete();
        for (int i = 0; i < 60; i++)
            cyc(i == 0, 3, ((n_edge + 1) % 10) == 0);
        check("sparse_steps", upd_q.size(), 2);
        check("sparse_final", duty_out, 3);
        for (int i = 0; i < upd_q.size(); i++)
            check("sparse_on_wrap", upd_q[i] % 10, 0);
        for (int i = 1; i < upd_q.size(); i++)
            check("sparse_gap_ok", (upd_q[i] - upd_q[i-1]) >= STEP_DIV, 1);

        // random targets, random period_wrap, valid offered at any time
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 15), $urandom_range(0, 2) == 0);
        repeat (60) cyc(1'b0, 0, 1'b1);

        // reset in the middle of a 5 -> 8 ramp
        cyc(1'b1, 5, 1'b1);
        repeat (40) cyc(1'b0, 0, 1'b1);
        cyc(1'b1, 8, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cyc(1'b0, 0, 1'b1);
            hit = (m_duty == 6);
        end
        check("mid_ramp_reached_6", hit, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_duty", duty_out, DUTY_INIT);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_update", duty_update, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        n_edge += 2;
        rst_n = 1'b1;
        model_reset();
        repeat (10) cyc(1'b0, 0, 1'b1);
        check("post_rst_duty", duty_out, DUTY_INIT);

`ifdef PWM_SEQ_RETARGET_EN
        // retarget from 8 to 5 once duty has reached 6
        cyc(1'b1, 8, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cyc(1'b0, 0, 1'b1);
            hit = (m_duty == 6);
        end
        check("retarget_reached_6", hit, 1);
        cyc(1'b1, 5, 1'b1);
        repeat (20) cyc(1'b0, 0, 1'b1);
        check("retarget_final", duty_out, 5);
        check("retarget_idle", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
